sdram_wr_controller: RTL and testbench

//  Downstream stage of the FIFO read controller. Handshakes one 1-KB block (512 x 16-bit words)
//  out of the TX FIFO, captures it into an internal block buffer at full FIFO rate, then drains
//  it to the SDRAM core through a req/ack write port at successive addresses.

---
 rtl/sdram_wr_controller_if.sv | 45 ++++
 rtl/sdram_wr_controller.sv | 160 ++++++++++++++++
 tb/tb_sdram_wr_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_controller_if.sv
// Block handshake and SDRAM write-port bundle for sdram_wr_controller.
// master = controller side, slave = read ctrl / SDRAM core side.
interface sdram_wr_controller_if #(
   parameter int ADDR_W = 22
);
   logic              fifo_tx_rdy;
   logic              sdram_rx_rdy;
   logic              fifo_rdreq;
   logic [15:0]       fifo_q;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              wr_ack;
   logic              block_done;
   logic              addr_wrap;
   logic [15:0]       err_cnt;

   modport master (
      input  fifo_tx_rdy,
      input  fifo_rdreq,
      input  fifo_q,
      input  wr_ack,
      output sdram_rx_rdy,
      output wr_req,
      output wr_addr,
      output wr_data,
      output block_done,
      output addr_wrap,
      output err_cnt
   );

   modport slave (
      output fifo_tx_rdy,
      output fifo_rdreq,
      output fifo_q,
      output wr_ack,
      input  sdram_rx_rdy,
      input  wr_req,
      input  wr_addr,
      input  wr_data,
      input  block_done,
      input  addr_wrap,
      input  err_cnt
   );
endinterface

// File: rtl/sdram_wr_controller.sv
// Captures one FIFO block into a local buffer, then drains it to SDRAM.
// Optional pattern checker enabled by defining STREAM_CHECK_EN.
module sdram_wr_controller #(
   parameter int              BURST_LEN  = 512,
   parameter int              ADDR_W     = 22,
   parameter longint unsigned BASE_ADDR  = 0,
   parameter longint unsigned LIMIT_ADDR = (64'd1 << ADDR_W) - 1
) (
   input logic                   clk,
   input logic                   rst,
   sdram_wr_controller_if.master bus
);

   localparam int AW = $clog2(BURST_LEN);
   localparam int CW = AW + 1;

   localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(LIMIT_ADDR);
   localparam logic [CW-1:0]     FULL  = CW'(BURST_LEN);
   localparam logic [CW-1:0]     LAST  = CW'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   logic              valid_d;
   logic [CW-1:0]     wcnt;
   logic [CW-1:0]     rcnt;
   logic [CW-1:0]     rcnt_nx;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wr_data_q;
   logic [15:0]       mem [BURST_LEN];

   logic cap_we;
   logic acked;
   logic last_ack;
   logic at_limit;

   assign cap_we   = (state == S_CAPTURE) && valid_d && (wcnt != FULL);
   assign acked    = (state == S_DRAIN) && bus.wr_ack;
   assign last_ack = acked && (rcnt == LAST);
   assign at_limit = (addr == LIMIT);
   assign rcnt_nx  = rcnt + 1'b1;

   assign bus.wr_addr = addr;
   assign bus.wr_data = wr_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx         = state;
      bus.sdram_rx_rdy = 1'b0;
      bus.wr_req       = 1'b0;
      bus.block_done   = 1'b0;
      bus.addr_wrap    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.fifo_tx_rdy) begin
               state_nx = S_START;
            end
         end
         S_START: begin
            bus.sdram_rx_rdy = 1'b1;
            state_nx         = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (wcnt == FULL) begin
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            bus.wr_req    = 1'b1;
            bus.addr_wrap = bus.wr_ack && at_limit;
            if (last_ack) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            bus.block_done = 1'b1;
            state_nx       = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Buffer contents carry no reset; only the counters define validity.
   always_ff @(posedge clk) begin
      if (cap_we) begin
         mem[wcnt[AW-1:0]] <= bus.fifo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_d   <= 1'b0;
         wcnt      <= '0;
         rcnt      <= '0;
         addr      <= BASE;
         wr_data_q <= '0;
      end else begin
         valid_d <= bus.fifo_rdreq;
         if (cap_we) begin
            wcnt <= wcnt + 1'b1;
         end
         // Preload word 0 so it is on the bus the first DRAIN cycle.
         if (state == S_CAPTURE && wcnt == FULL) begin
            wr_data_q <= mem[0];
         end
         if (acked) begin
            rcnt <= rcnt_nx;
            addr <= at_limit ? BASE : addr + 1'b1;
            if (!last_ack) begin
               wr_data_q <= mem[rcnt_nx[AW-1:0]];
            end
         end
         if (state == S_DONE) begin
            wcnt <= '0;
            rcnt <= '0;
         end
      end
   end

`ifdef STREAM_CHECK_EN
   logic [15:0] exp_word;
   logic [15:0] err_q;

   // On mismatch the expected counter resyncs to the received word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_word <= '0;
         err_q    <= '0;
      end else if (cap_we) begin
         if (bus.fifo_q != exp_word && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
         end
         exp_word <= bus.fifo_q + 16'd1;
      end
   end

   assign bus.err_cnt = err_q;
`else
   assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_sdram_wr_controller.sv
// Randomized bench for sdram_wr_controller against a block/address model.
// Pattern-check expectations follow STREAM_CHECK_EN.
module tb_sdram_wr_controller;

   localparam int          BL    = 512;
   localparam int          LIMIT = 1023;
   localparam logic [21:0] BASE  = '0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sdram_wr_controller_if #(.ADDR_W(22)) bus ();

   sdram_wr_controller #(
      .BURST_LEN (BL),
      .ADDR_W    (22),
      .BASE_ADDR (0),
      .LIMIT_ADDR(LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [21:0] m_addr;
   logic [15:0] m_src;
   logic [15:0] m_exp;
   logic [15:0] m_err;
   logic [15:0] blk [$];

   int n_words;
   int n_rx;
   int n_done;
   int n_wrap;
   bit rst_hit;
   bit finished;

   function automatic void model_reset();
      m_addr = BASE;
      m_src  = '0;
      m_exp  = '0;
      m_err  = '0;
   endfunction

   function automatic logic [15:0] exp_err();
`ifdef STREAM_CHECK_EN
      return m_err;
`else
      return 16'd0;
`endif
   endfunction

   // Source stream: counter; a corrupted word restarts the count from it.
   task automatic make_block(input int corrupt_idx);
      logic [15:0] w;
      blk.delete();
      for (int i = 0; i < BL; i++) begin
         w = (i == corrupt_idx) ? 16'hBEEF : m_src;
         blk.push_back(w);
         m_src = w + 16'd1;
         if (w != m_exp && m_err != 16'hFFFF) m_err = m_err + 16'd1;
         m_exp = w + 16'd1;
      end
   endtask

   task automatic run_block(input int ack_pct, input int gap_pct,
                            input int extra, input bit hold_rdy,
                            input int rst_at);
      int rd_left;
      int cyc;
      int widx;
      int fq_idx;
      bit rd_prev;
      bit started;
      bit stall;
      logic [21:0] pa;
      logic [15:0] pd;
      rd_left  = BL + extra;
      cyc      = 0;
      widx     = 0;
      fq_idx   = 0;
      rd_prev  = 0;
      started  = 0;
      stall    = 0;
      pa       = '0;
      pd       = '0;
      n_rx     = 0;
      n_done   = 0;
      n_wrap   = 0;
      rst_hit  = 0;
      finished = 0;
      bus.fifo_tx_rdy = 1'b1;
      while (!finished && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (bus.sdram_rx_rdy) begin
            n_rx++;
            started = 1;
            if (!hold_rdy) bus.fifo_tx_rdy = 1'b0;
         end
         if (bus.block_done) begin
            n_done++;
            finished = 1;
            bus.fifo_tx_rdy = 1'b0;
         end
         if (rst_at >= 0 && widx == rst_at) begin
            rst             = 1'b1;
            rst_hit         = 1;
            finished        = 1;
            bus.fifo_rdreq  = 1'b0;
            bus.wr_ack      = 1'b0;
            bus.fifo_tx_rdy = 1'b0;
         end else begin
            if (rd_prev) begin
               bus.fifo_q = (fq_idx < BL) ? blk[fq_idx] : 16'($urandom);
               fq_idx++;
            end
            rd_prev = started && rd_left > 0 &&
                      $urandom_range(99) >= gap_pct;
            if (rd_prev) rd_left--;
            bus.fifo_rdreq = rd_prev;
            bus.wr_ack = ($urandom_range(99) < ack_pct);
            #1;
            if (bus.addr_wrap) n_wrap++;
            if (bus.wr_req) begin
               if (stall) begin
                  checks++;
                  if (bus.wr_addr !== pa || bus.wr_data !== pd) begin
                     errors++;
                     $display("FAIL stable: addr %0d data %h, required %0d %h",
                              bus.wr_addr, bus.wr_data, pa, pd);
                  end
               end
               if (bus.wr_ack) begin
                  checks++;
                  if (widx >= BL) begin
                     errors++;
                     $display("FAIL extra_word: index %0d, required < %0d",
                              widx, BL);
                  end else begin
                     if (bus.wr_addr !== m_addr) begin
                        errors++;
                        $display("FAIL wr_addr[%0d]: got %0d, required %0d",
                                 widx, bus.wr_addr, m_addr);
                     end
                     checks++;
                     if (bus.wr_data !== blk[widx]) begin
                        errors++;
                        $display("FAIL wr_data[%0d]: got %h, required %h",
                                 widx, bus.wr_data, blk[widx]);
                     end
                     checks++;
                     if (bus.addr_wrap !== (m_addr == LIMIT)) begin
                        errors++;
                        $display("FAIL addr_wrap[%0d]: got %b, required %b",
                                 widx, bus.addr_wrap, (m_addr == LIMIT));
                     end
                  end
                  m_addr = (m_addr == LIMIT) ? BASE : m_addr + 22'd1;
                  widx++;
                  stall = 0;
               end else begin
                  stall = 1;
                  pa    = bus.wr_addr;
                  pd    = bus.wr_data;
               end
            end else begin
               stall = 0;
               checks++;
               if (bus.addr_wrap !== 1'b0) begin
                  errors++;
                  $display("FAIL idle_wrap: got %b, required 0", bus.addr_wrap);
               end
            end
         end
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL timeout: block not finished after %0d cycles, words %0d",
                  cyc, widx);
      end
      if (!rst_hit) begin
         bus.fifo_rdreq = 1'b0;
         bus.wr_ack     = 1'b0;
      end
      n_words = widx;
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.fifo_tx_rdy = 1'b0;
      bus.fifo_rdreq  = 1'b0;
      bus.fifo_q      = '0;
      bus.wr_ack      = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.sdram_rx_rdy, bus.wr_req, bus.block_done, bus.addr_wrap}
             !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs cyc %0d: rx %b req %b done %b wrap %b, required 0",
                     i, bus.sdram_rx_rdy, bus.wr_req, bus.block_done, bus.addr_wrap);
         end
      end
      checks++;
      if (bus.wr_addr !== BASE) begin
         errors++;
         $display("FAIL reset_addr: got %0d, required %0d", bus.wr_addr, BASE);
      end
      checks++;
      if (bus.wr_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: got %h, required 0000", bus.wr_data);
      end
      checks++;
      if (bus.err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_err: got %0d, required 0", bus.err_cnt);
      end
   endtask

   task automatic test_basic();
      make_block(-1);
      run_block(100, 0, 0, 0, -1);
      checks++;
      if (n_rx !== 1 || n_done !== 1 || n_words !== BL) begin
         errors++;
         $display("FAIL basic_counts: rx %0d done %0d words %0d, required 1 1 %0d",
                  n_rx, n_done, n_words, BL);
      end
      @(negedge clk);
      checks++;
      if (bus.wr_addr !== m_addr) begin
         errors++;
         $display("FAIL basic_next_addr: got %0d, required %0d", bus.wr_addr, m_addr);
      end
      checks++;
      if (bus.err_cnt !== exp_err()) begin
         errors++;
         $display("FAIL basic_err: got %0d, required %0d", bus.err_cnt, exp_err());
      end
   endtask

   task automatic test_back_to_back();
      make_block(-1);
      run_block(100, 0, 0, 1, -1);
      checks++;
      if (n_rx !== 1 || n_done !== 1 || n_words !== BL) begin
         errors++;
         $display("FAIL b2b_counts: rx %0d done %0d words %0d, required 1 1 %0d",
                  n_rx, n_done, n_words, BL);
      end
      checks++;
      if (n_wrap !== 1) begin
         errors++;
         $display("FAIL b2b_wrap_count: got %0d, required 1", n_wrap);
      end
   endtask

   task automatic test_wrap();
      make_block(-1);
      run_block(100, 0, 0, 0, -1);
      checks++;
      if (n_words !== BL || n_wrap !== 0) begin
         errors++;
         $display("FAIL wrap_third: words %0d wraps %0d, required %0d 0",
                  n_words, n_wrap, BL);
      end
      checks++;
      if (m_addr !== 22'd512) begin
         errors++;
         $display("FAIL wrap_model_addr: got %0d, required 512", m_addr);
      end
   endtask

   task automatic test_random_ack();
      make_block(-1);
      run_block(25, 30, 2, 0, -1);
      checks++;
      if (n_rx !== 1 || n_done !== 1 || n_words !== BL) begin
         errors++;
         $display("FAIL rand_counts: rx %0d done %0d words %0d, required 1 1 %0d",
                  n_rx, n_done, n_words, BL);
      end
      checks++;
      if (bus.err_cnt !== exp_err()) begin
         errors++;
         $display("FAIL rand_err: got %0d, required %0d", bus.err_cnt, exp_err());
      end
   endtask

   task automatic test_reset_mid();
      make_block(-1);
      run_block(70, 10, 0, 0, 200);
      checks++;
      if (rst_hit !== 1'b1 || n_words !== 200) begin
         errors++;
         $display("FAIL mid_reset_hit: hit %b words %0d, required 1 200",
                  rst_hit, n_words);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.wr_req !== 1'b0 || bus.wr_addr !== BASE) begin
            errors++;
            $display("FAIL in_reset: req %b addr %0d, required 0 %0d",
                     bus.wr_req, bus.wr_addr, BASE);
         end
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (bus.wr_req !== 1'b0 || bus.sdram_rx_rdy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: req %b rx %b, required 0 0",
                     bus.wr_req, bus.sdram_rx_rdy);
         end
      end
      make_block(-1);
      run_block(100, 0, 0, 0, -1);
      checks++;
      if (n_rx !== 1 || n_done !== 1 || n_words !== BL) begin
         errors++;
         $display("FAIL restart_counts: rx %0d done %0d words %0d, required 1 1 %0d",
                  n_rx, n_done, n_words, BL);
      end
   endtask

   task automatic test_stream_check();
      make_block(100);
      run_block(60, 20, 0, 0, -1);
      checks++;
      if (n_words !== BL || n_done !== 1) begin
         errors++;
         $display("FAIL stream_counts: words %0d done %0d, required %0d 1",
                  n_words, n_done, BL);
      end
      checks++;
      if (bus.err_cnt !== exp_err()) begin
         errors++;
         $display("FAIL stream_err: got %0d, required %0d", bus.err_cnt, exp_err());
      end
      make_block(-1);
      run_block(100, 0, 0, 0, -1);
      checks++;
      if (bus.err_cnt !== exp_err()) begin
         errors++;
         $display("FAIL stream_err_after: got %0d, required %0d",
                  bus.err_cnt, exp_err());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_wrap();
      test_random_ack();
      test_reset_mid();
      test_stream_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
